// File: rtl/star_field_sequencer.sv
// Starfield background layer: per-frame LFSR reseed and pseudo-random star placement
// along the active raster, with density-scaled gaps and optional per-frame scrolling.
module star_field_sequencer #(
    parameter int          WIDTH     = 640,
    parameter int          HEIGHT    = 480,
    parameter logic [10:0] SEED_BASE = 11'h5A5,
    parameter logic [11:0] STAR_RGB  = 12'hFFF,
    parameter logic [11:0] DIM_RGB   = 12'h777
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        enable,
    input  logic [1:0]  density,
    input  logic        scroll_en,
    input  logic        pxl_valid,
    input  logic [10:0] pxl_x,
    input  logic [10:0] pxl_y,
    output logic        star_draw,
    output logic [11:0] star_rgb,
    output logic [7:0]  frame_cnt,
    output logic [11:0] last_frame_stars
);

    // A zero seed would lock the LFSR; the raster must also be non-empty.
    if (SEED_BASE[10:8] == 3'b000 || WIDTH < 1 || HEIGHT < 1) begin : g_param_check
        $error("star_field_sequencer: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] lfsr_q, lfsr_d;
    logic [10:0] cnt_q, cnt_d;
    logic [11:0] star_acc_q, star_acc_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [11:0] last_stars_q, last_stars_d;
    logic        star_draw_q, star_draw_d;
    logic [11:0] star_rgb_q, star_rgb_d;

    logic        fs;
    logic [10:0] lfsr_next;
    logic [10:0] seed;

    assign fs        = pxl_valid && (pxl_x == 11'd0) && (pxl_y == 11'd0);
    assign lfsr_next = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    assign seed      = SEED_BASE ^ {3'b000, (scroll_en ? frame_cnt_q : 8'd0)};

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cnt_d        = cnt_q;
        star_acc_d   = star_acc_q;
        frame_cnt_d  = frame_cnt_q;
        last_stars_d = last_stars_q;
        star_draw_d  = 1'b0;
        star_rgb_d   = 12'h000;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT;
                WAIT, RUN: begin
                    if (fs) begin
                        // Frame origin: reseed, publish last frame's count, never draw here.
                        state_d      = RUN;
                        lfsr_d       = seed;
                        cnt_d        = seed >> density;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        last_stars_d = star_acc_q;
                        star_acc_d   = 12'h000;
                    end else if (state_q == RUN && pxl_valid) begin
                        if (cnt_q != 11'd0) begin
                            cnt_d = cnt_q - 11'd1;
                        end else begin
                            star_draw_d = 1'b1;
                            star_rgb_d  = (frame_cnt_q[3] && lfsr_q[0]) ? DIM_RGB : STAR_RGB;
                            lfsr_d      = lfsr_next;
                            cnt_d       = lfsr_next >> density;
                            if (star_acc_q != 12'hFFF) begin
                                star_acc_d = star_acc_q + 12'd1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED_BASE;
            cnt_q        <= 11'd0;
            star_acc_q   <= 12'h000;
            frame_cnt_q  <= 8'd0;
            last_stars_q <= 12'h000;
            star_draw_q  <= 1'b0;
            star_rgb_q   <= 12'h000;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            star_acc_q   <= star_acc_d;
            frame_cnt_q  <= frame_cnt_d;
            last_stars_q <= last_stars_d;
            star_draw_q  <= star_draw_d;
            star_rgb_q   <= star_rgb_d;
        end
    end

    assign star_draw        = star_draw_q;
    assign star_rgb         = star_rgb_q;
    assign frame_cnt        = frame_cnt_q;
    assign last_frame_stars = last_stars_q;

endmodule

// File: tb/tb_star_field_sequencer.sv
// Bench for star_field_sequencer: raster driver, index-based star model feeding an
// expected queue, and a monitor that compares every registered output cycle.
module tb_star_field_sequencer;

    localparam logic [10:0] SEED_BASE = 11'h5A5;
    localparam logic [11:0] STAR_RGB  = 12'hFFF;
    localparam logic [11:0] DIM_RGB   = 12'h777;

    logic        clk = 1'b0;
    logic        resetN;
    logic        enable;
    logic [1:0]  density;
    logic        scroll_en;
    logic        pxl_valid;
    logic [10:0] pxl_x;
    logic [10:0] pxl_y;
    logic        star_draw;
    logic [11:0] star_rgb;
    logic [7:0]  frame_cnt;
    logic [11:0] last_frame_stars;

    star_field_sequencer #(
        .WIDTH(640), .HEIGHT(480), .SEED_BASE(SEED_BASE),
        .STAR_RGB(STAR_RGB), .DIM_RGB(DIM_RGB)
    ) dut (
        .clk(clk), .resetN(resetN), .enable(enable), .density(density),
        .scroll_en(scroll_en), .pxl_valid(pxl_valid), .pxl_x(pxl_x), .pxl_y(pxl_y),
        .star_draw(star_draw), .star_rgb(star_rgb), .frame_cnt(frame_cnt),
        .last_frame_stars(last_frame_stars)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scoreboard queues: expected {draw, rgb, frame_cnt, last_stars} and the pixel that caused it
    logic [32:0] exp_q[$];
    logic [22:0] pix_q[$];

    // stimulus controls applied by the driver at each negedge
    logic       cur_en = 1'b0;
    logic [1:0] cur_dens = 2'd0;
    logic       cur_scr = 1'b0;

    // monitor observations
    logic        cap_first = 1'b0;
    int          first_x = -1;
    int          first_y = -1;
    logic [11:0] first_rgb = 12'h000;
    int          dim_cnt = 0;
    int          blank_star_cnt = 0;

    // reference model: next star is tracked as an absolute active-pixel index within the frame
    int          m_mode;
    logic [10:0] m_lfsr;
    int          m_pix;
    int          m_next;
    logic [7:0]  m_fc;
    logic [11:0] m_acc;
    logic [11:0] m_last;
    logic        m_draw;
    logic [11:0] m_rgb;

    function automatic logic [10:0] lfsr_step(input logic [10:0] l);
        return {l[9:0], l[10] ^ l[8]};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_lfsr = SEED_BASE; m_pix = 0; m_next = 0;
        m_fc = 8'd0; m_acc = 12'h000; m_last = 12'h000; m_draw = 1'b0; m_rgb = 12'h000;
    endtask

    task automatic model_step(input logic en, input logic [1:0] dens, input logic scr,
                              input logic v, input int x, input int y);
        logic [10:0] seed;
        m_draw = 1'b0;
        m_rgb  = 12'h000;
        if (!en) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (v && x == 0 && y == 0) begin
            seed   = SEED_BASE ^ {3'b000, (scr ? m_fc : 8'd0)};
            m_lfsr = seed;
            m_pix  = 0;
            m_next = int'(seed >> dens) + 1;
            m_fc   = m_fc + 8'd1;
            m_last = m_acc;
            m_acc  = 12'h000;
            m_mode = 2;
        end else if (m_mode == 2 && v) begin
            m_pix = m_pix + 1;
            if (m_pix == m_next) begin
                m_draw = 1'b1;
                m_rgb  = (m_fc[3] && m_lfsr[0]) ? DIM_RGB : STAR_RGB;
                m_lfsr = lfsr_step(m_lfsr);
                m_next = m_pix + int'(m_lfsr >> dens) + 1;
                if (m_acc != 12'hFFF) m_acc = m_acc + 12'd1;
            end
        end
    endtask

    // driver tasks
    task automatic drive(input logic v, input int x, input int y);
        @(negedge clk);
        enable    = cur_en;
        density   = cur_dens;
        scroll_en = cur_scr;
        pxl_valid = v;
        pxl_x     = 11'(x);
        pxl_y     = 11'(y);
        model_step(cur_en, cur_dens, cur_scr, v, x, y);
        exp_q.push_back({m_draw, m_rgb, m_fc, m_last});
        pix_q.push_back({v, 11'(x), 11'(y)});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 2047), $urandom_range(0, 2047));
    endtask

    // one raster frame; enable drops before pixel (dx,dy) and returns before pixel (ex,ey)
    task automatic run_frame(input int w, input int h, input int hb, input bit rnd,
                             input int dx, input int dy, input int ex, input int ey);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (x == dx && y == dy) cur_en = 1'b0;
                if (x == ex && y == ey) cur_en = 1'b1;
                if (rnd && $urandom_range(0, 7) == 0) idle_cycles(1);
                drive(1'b1, x, y);
            end
            idle_cycles(hb);
        end
        idle_cycles(hb * 4);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // asserts reset between edges; outputs must clear without a clock
    task automatic do_reset();
        resetN = 1'b0;
        #1;
        check("rst_draw", int'(star_draw), 0);
        check("rst_rgb", int'(star_rgb), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_last_stars", int'(last_frame_stars), 0);
        model_reset();
        #1;
        resetN = 1'b1;
    endtask

    // monitor: pops one expectation per clock, one cycle after its pixel was driven
    initial begin
        logic [32:0] e;
        logic [22:0] p;
        logic [32:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                p   = pix_q.pop_front();
                got = {star_draw, star_rgb, frame_cnt, last_frame_stars};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL out at v=%0d (%0d,%0d): got draw=%0d rgb=%h fc=%0d last=%0d, want draw=%0d rgb=%h fc=%0d last=%0d",
                             p[22], p[21:11], p[10:0], got[32], got[31:20], got[19:12], got[11:0],
                             e[32], e[31:20], e[19:12], e[11:0]);
                end
                if (star_draw) begin
                    if (!p[22]) blank_star_cnt++;
                    if (star_rgb == DIM_RGB) dim_cnt++;
                    if (cap_first) begin
                        first_x   = int'(p[21:11]);
                        first_y   = int'(p[10:0]);
                        first_rgb = star_rgb;
                        cap_first = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int fc_before;
        resetN = 1'b0; enable = 1'b0; density = 2'd0; scroll_en = 1'b0;
        pxl_valid = 1'b0; pxl_x = 11'd0; pxl_y = 11'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        do_reset();

        // density 3 from reset: first star right after the 180-pixel gap
        cur_en = 1'b1; cur_dens = 2'd3; cur_scr = 1'b0;
        idle_cycles(3);
        cap_first = 1'b1;
        run_frame(640, 4, 8, 1'b0, -1, -1, -1, -1);
        drain();
        check("s1_first_x", first_x, 181);
        check("s1_first_y", first_y, 0);
        check("s1_first_rgb", int'(first_rgb), 12'hFFF);
        check("s1_frame_cnt", int'(frame_cnt), 1);

        // density 0 with random blanking inserted mid-line
        cur_dens = 2'd0; cap_first = 1'b1; blank_star_cnt = 0;
        run_frame(640, 4, 8, 1'b1, -1, -1, -1, -1);
        drain();
        check("s2_first_x", first_x, 166);
        check("s2_first_y", first_y, 2);
        check("s2_blank_stars", blank_star_cnt, 0);

        // scrolling: second frame seeds from 0x5A5 ^ 1
        do_reset();
        cur_scr = 1'b1; cur_dens = 2'd0;
        idle_cycles(3);
        cap_first = 1'b1;
        run_frame(640, 4, 8, 1'b0, -1, -1, -1, -1);
        drain();
        check("s3_f1_x", first_x, 166);
        check("s3_f1_y", first_y, 2);
        cap_first = 1'b1;
        run_frame(640, 4, 8, 1'b0, -1, -1, -1, -1);
        drain();
        check("s3_f2_x", first_x, 165);
        check("s3_f2_y", first_y, 2);

        // mid-frame disable and re-enable
        cur_scr = 1'b0; cur_dens = 2'd2;
        fc_before = int'(frame_cnt);
        run_frame(32, 24, 4, 1'b0, 20, 10, 10, 20);
        drain();
        check("s4_frame_cnt_held", int'(frame_cnt), (fc_before + 1) % 256);
        run_frame(32, 24, 4, 1'b0, -1, -1, -1, -1);
        drain();
        check("s4_frame_cnt_next", int'(frame_cnt), (fc_before + 2) % 256);

        // randomized frames with per-frame density and scroll
        for (int f = 0; f < 8; f++) begin
            cur_dens = 2'($urandom_range(0, 3));
            cur_scr  = 1'($urandom_range(0, 1));
            run_frame(64, 8, 3, 1'b1, -1, -1, -1, -1);
        end
        drain();

        // async reset mid-line, then the density-3 sequence must repeat exactly
        cur_dens = 2'd3; cur_scr = 1'b0;
        idle_cycles(2);
        for (int x = 0; x < 200; x++) drive(1'b1, x, 0);
        drain();
        do_reset();
        idle_cycles(3);
        cap_first = 1'b1;
        run_frame(640, 4, 8, 1'b0, -1, -1, -1, -1);
        drain();
        check("s6_first_x", first_x, 181);
        check("s6_first_y", first_y, 0);
        check("s6_frame_cnt", int'(frame_cnt), 1);

        // 256 frames from reset: frame_cnt wraps; wide frames while frame_cnt[3]=1 for dim stars
        do_reset();
        cur_dens = 2'd3; cur_scr = 1'b1; dim_cnt = 0;
        idle_cycles(3);
        for (int f = 0; f < 256; f++) begin
            if (f >= 7 && f <= 14) run_frame(320, 2, 2, 1'b0, -1, -1, -1, -1);
            else run_frame(8, 2, 2, 1'b0, -1, -1, -1, -1);
        end
        drain();
        check("wrap_frame_cnt", int'(frame_cnt), 0);
        checks++;
        if (dim_cnt == 0) begin
            errors++;
            $display("FAIL dim_seen: got %0d dim stars, want at least 1", dim_cnt);
        end
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
